// File: rtl/dfr_readout_if.sv
// dfr_readout_if: frame control, weight load and result bus of the reservoir readout layer.
interface dfr_readout_if #(
    parameter int DATA_WIDTH   = 32,
    parameter int WEIGHT_WIDTH = 32,
    parameter int ACC_WIDTH    = 64,
    parameter int ADDR_WIDTH   = 4
);
    logic                    start;
    logic                    node_valid;
    logic [DATA_WIDTH-1:0]   node_din;
    logic                    weight_wr_en;
    logic [ADDR_WIDTH-1:0]   weight_addr;
    logic [WEIGHT_WIDTH-1:0] weight_din;
    logic                    busy;
    logic                    y_valid;
    logic [ACC_WIDTH-1:0]    y_dout;

    modport master (
        output start, node_valid, node_din, weight_wr_en, weight_addr, weight_din,
        input  busy, y_valid, y_dout
    );

    modport slave (
        input  start, node_valid, node_din, weight_wr_en, weight_addr, weight_din,
        output busy, y_valid, y_dout
    );
endinterface

// File: rtl/dfr_readout.sv
// dfr_readout: saturating dot product of one frame of node states with loaded output weights.
module dfr_readout #(
    parameter int VIRTUAL_NODES = 10,
    parameter int DATA_WIDTH    = 32,
    parameter int WEIGHT_WIDTH  = 32,
    parameter int ACC_WIDTH     = 64,
    parameter int ADDR_WIDTH    = $clog2(VIRTUAL_NODES)
) (
    input logic         clk,
    input logic         rst,
    dfr_readout_if.slave rd
);
    localparam int PW = DATA_WIDTH + WEIGHT_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(VIRTUAL_NODES - 1);

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t                  state_q;
    logic [ADDR_WIDTH-1:0]   idx_q;
    logic [ACC_WIDTH-1:0]    acc_q, acc_d, y_dout_q;
    logic                    y_valid_q, busy_q;
    logic [WEIGHT_WIDTH-1:0] weight_q [VIRTUAL_NODES];
    logic [PW-1:0]           prod;
    logic [ACC_WIDTH:0]      sum;

    // The carry out of the widened sum flags overflow; adding to all-ones keeps it saturated.
    always_comb begin
        prod  = PW'(rd.node_din) * PW'(weight_q[idx_q]);
        sum   = {1'b0, acc_q} + (ACC_WIDTH + 1)'(prod);
        acc_d = sum[ACC_WIDTH] ? '1 : sum[ACC_WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            acc_q     <= '0;
            y_dout_q  <= '0;
            y_valid_q <= 1'b0;
            busy_q    <= 1'b0;
            for (int i = 0; i < VIRTUAL_NODES; i++) weight_q[i] <= '0;
        end else begin
            if (rd.weight_wr_en && rd.weight_addr <= LAST) weight_q[rd.weight_addr] <= rd.weight_din;
            y_valid_q <= 1'b0;
            case (state_q)
                IDLE: if (rd.start) begin
                    state_q <= ACCUM;
                    acc_q   <= '0;
                    idx_q   <= '0;
                    busy_q  <= 1'b1;
                end
                ACCUM: if (rd.start) begin
                    acc_q <= '0;
                    idx_q <= '0;
                end else if (rd.node_valid) begin
                    acc_q <= acc_d;
                    if (idx_q == LAST) begin
                        // Result is published on the edge entering DONE so it lines up with y_valid.
                        state_q   <= DONE;
                        idx_q     <= '0;
                        y_dout_q  <= acc_d;
                        y_valid_q <= 1'b1;
                    end else begin
                        idx_q <= idx_q + ADDR_WIDTH'(1);
                    end
                end
                DONE: begin
                    state_q <= rd.start ? ACCUM : IDLE;
                    busy_q  <= rd.start;
                    acc_q   <= '0;
                    idx_q   <= '0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign rd.busy    = busy_q;
    assign rd.y_valid = y_valid_q;
    assign rd.y_dout  = y_dout_q;
endmodule

// File: tb/tb_dfr_readout.sv
// tb_dfr_readout: scenario tasks checked against a sum-of-products reference with a saturation cap.
module tb_dfr_readout;
    localparam int VN = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dfr_readout_if #(.DATA_WIDTH(32), .WEIGHT_WIDTH(32), .ACC_WIDTH(64), .ADDR_WIDTH(4)) rd ();

    dfr_readout #(.VIRTUAL_NODES(VN)) dut (.clk(clk), .rst(rst), .rd(rd));

    int total = 0;
    int bad = 0;
    int yv_count = 0;
    logic [31:0] model_w [VN];
    logic [31:0] din [VN];

    always @(negedge clk) if (rd.y_valid === 1'b1) yv_count++;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_w(input int a, input logic [31:0] v);
        rd.weight_wr_en = 1'b1;
        rd.weight_addr  = a[3:0];
        rd.weight_din   = v;
        step();
        rd.weight_wr_en = 1'b0;
        if (a < VN) model_w[a] = v;
    endtask

    task automatic load_ramp();
        for (int i = 0; i < VN; i++) write_w(i, 32'(i + 1));
    endtask

    task automatic set_din(input logic [31:0] v);
        for (int i = 0; i < VN; i++) din[i] = v;
    endtask

    function automatic logic [63:0] model_result();
        logic [127:0] s = '0;
        for (int i = 0; i < VN; i++) s += 128'(din[i]) * 128'(model_w[i]);
        return (s[127:64] != 0) ? 64'hFFFF_FFFF_FFFF_FFFF : s[63:0];
    endfunction

    // Leaves the bench 1 time unit after the edge that accepted the last node.
    task automatic feed(input int gap, input bit do_start);
        if (do_start) begin
            rd.start = 1'b1;
            step();
            rd.start = 1'b0;
        end
        for (int i = 0; i < VN; i++) begin
            rd.node_valid = 1'b1;
            rd.node_din   = din[i];
            step();
            rd.node_valid = 1'b0;
            if (i != VN - 1) repeat (gap) begin
                rd.node_din = $urandom;
                step();
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        for (int i = 0; i < VN; i++) model_w[i] = '0;
        total++; if (rd.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", rd.busy); end
        total++; if (rd.y_valid !== 1'b0) begin bad++; $display("FAIL reset_y_valid got=%b exp=0", rd.y_valid); end
        total++; if (rd.y_dout !== 64'h0) begin bad++; $display("FAIL reset_y_dout got=%h exp=0", rd.y_dout); end
    endtask

    task automatic test_contiguous();
        load_ramp();
        set_din(32'h0010_0000);
        rd.start = 1'b1;
        step();
        rd.start = 1'b0;
        total++; if (rd.busy !== 1'b1) begin bad++; $display("FAIL contig_busy_accum got=%b exp=1", rd.busy); end
        feed(0, 1'b0);
        total++; if (rd.y_valid !== 1'b1) begin bad++; $display("FAIL contig_y_valid got=%b exp=1", rd.y_valid); end
        total++; if (rd.y_dout !== 64'h0370_0000) begin bad++; $display("FAIL contig_y_dout got=%h exp=%h", rd.y_dout, 64'h0370_0000); end
        total++; if (rd.busy !== 1'b1) begin bad++; $display("FAIL contig_busy_done got=%b exp=1", rd.busy); end
        step();
        total++; if (rd.y_valid !== 1'b0) begin bad++; $display("FAIL contig_y_valid_pulse got=%b exp=0", rd.y_valid); end
        total++; if (rd.busy !== 1'b0) begin bad++; $display("FAIL contig_busy_after got=%b exp=0", rd.busy); end
        total++; if (rd.y_dout !== 64'h0370_0000) begin bad++; $display("FAIL contig_y_dout_hold got=%h exp=%h", rd.y_dout, 64'h0370_0000); end
    endtask

    task automatic test_gapped();
        int c0 = yv_count;
        set_din(32'h0010_0000);
        feed(2, 1'b1);
        total++; if (rd.y_valid !== 1'b1) begin bad++; $display("FAIL gapped_y_valid got=%b exp=1", rd.y_valid); end
        total++; if (rd.y_dout !== 64'h0370_0000) begin bad++; $display("FAIL gapped_y_dout got=%h exp=%h", rd.y_dout, 64'h0370_0000); end
        step();
        total++; if (yv_count - c0 !== 1) begin bad++; $display("FAIL gapped_pulses got=%0d exp=1", yv_count - c0); end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < VN; i++) write_w(i, 32'hFFFF_FFFF);
        write_w(12, 32'h0);
        set_din(32'hFFFF_FFFF);
        feed(0, 1'b1);
        total++; if (rd.y_dout !== 64'hFFFF_FFFF_FFFF_FFFF) begin bad++; $display("FAIL sat_y_dout got=%h exp=%h", rd.y_dout, 64'hFFFF_FFFF_FFFF_FFFF); end
        total++; if (rd.y_dout !== model_result()) begin bad++; $display("FAIL sat_model got=%h exp=%h", rd.y_dout, model_result()); end
        step();
        load_ramp();
        write_w(10, 32'h0);
        write_w(15, 32'h0);
        set_din(32'd1);
        feed(1, 1'b1);
        total++; if (rd.y_dout !== 64'd55) begin bad++; $display("FAIL oob_write_y_dout got=%h exp=%h", rd.y_dout, 64'd55); end
        step();
    endtask

    task automatic test_abort();
        int c0 = yv_count;
        rd.start = 1'b1;
        step();
        rd.start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            rd.node_valid = 1'b1;
            rd.node_din   = 32'd7;
            step();
        end
        rd.start    = 1'b1;
        rd.node_din = 32'd1000;
        step();
        rd.start      = 1'b0;
        rd.node_valid = 1'b0;
        set_din(32'd1);
        feed(0, 1'b0);
        total++; if (rd.y_valid !== 1'b1) begin bad++; $display("FAIL abort_y_valid got=%b exp=1", rd.y_valid); end
        total++; if (rd.y_dout !== 64'd55) begin bad++; $display("FAIL abort_y_dout got=%h exp=%h", rd.y_dout, 64'd55); end
        step();
        total++; if (yv_count - c0 !== 1) begin bad++; $display("FAIL abort_pulses got=%0d exp=1", yv_count - c0); end
    endtask

    task automatic test_reset_midframe();
        int c0 = yv_count;
        rd.start = 1'b1;
        step();
        rd.start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            rd.node_valid = 1'b1;
            rd.node_din   = 32'd3;
            step();
        end
        rd.node_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < VN; i++) model_w[i] = '0;
        repeat (12) step();
        total++; if (yv_count !== c0) begin bad++; $display("FAIL rstmid_pulses got=%0d exp=%0d", yv_count, c0); end
        total++; if (rd.y_dout !== 64'h0) begin bad++; $display("FAIL rstmid_y_dout got=%h exp=0", rd.y_dout); end
        total++; if (rd.busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b exp=0", rd.busy); end
        set_din(32'd1);
        feed(0, 1'b1);
        total++; if (rd.y_valid !== 1'b1) begin bad++; $display("FAIL rstmid_frame_y_valid got=%b exp=1", rd.y_valid); end
        total++; if (rd.y_dout !== 64'h0) begin bad++; $display("FAIL rstmid_weights_cleared got=%h exp=0", rd.y_dout); end
        step();
    endtask

    task automatic test_read_before_write();
        load_ramp();
        set_din(32'd1);
        rd.start = 1'b1;
        step();
        rd.start = 1'b0;
        for (int i = 0; i < VN; i++) begin
            rd.node_valid = 1'b1;
            rd.node_din   = 32'd1;
            if (i == 3) begin
                rd.weight_wr_en = 1'b1;
                rd.weight_addr  = 4'd3;
                rd.weight_din   = 32'd100;
            end
            step();
            rd.weight_wr_en = 1'b0;
        end
        rd.node_valid = 1'b0;
        total++; if (rd.y_dout !== 64'd55) begin bad++; $display("FAIL rbw_old_weight got=%h exp=%h", rd.y_dout, 64'd55); end
        model_w[3] = 32'd100;
        step();
        feed(0, 1'b1);
        total++; if (rd.y_dout !== 64'd151) begin bad++; $display("FAIL rbw_new_weight got=%h exp=%h", rd.y_dout, 64'd151); end
        total++; if (rd.y_dout !== model_result()) begin bad++; $display("FAIL rbw_model got=%h exp=%h", rd.y_dout, model_result()); end
        step();
    endtask

    task automatic test_back_to_back();
        int c0 = yv_count;
        for (int i = 0; i < VN; i++) write_w(i, $urandom_range(0, 65535));
        for (int i = 0; i < VN; i++) din[i] = $urandom;
        feed(0, 1'b1);
        total++; if (rd.y_dout !== model_result()) begin bad++; $display("FAIL b2b_first got=%h exp=%h", rd.y_dout, model_result()); end
        for (int i = 0; i < VN; i++) din[i] = $urandom;
        feed(1, 1'b1);
        total++; if (rd.y_valid !== 1'b1) begin bad++; $display("FAIL b2b_second_y_valid got=%b exp=1", rd.y_valid); end
        total++; if (rd.y_dout !== model_result()) begin bad++; $display("FAIL b2b_second got=%h exp=%h", rd.y_dout, model_result()); end
        step();
        total++; if (yv_count - c0 !== 2) begin bad++; $display("FAIL b2b_pulses got=%0d exp=2", yv_count - c0); end
    endtask

    task automatic test_random();
        for (int f = 0; f < 8; f++) begin
            for (int k = 0; k < 4; k++) write_w($urandom_range(0, 15), (f % 2 == 0) ? $urandom : $urandom_range(0, 1000));
            for (int i = 0; i < VN; i++) din[i] = (f % 2 == 0) ? $urandom : $urandom_range(0, 1 << 20);
            feed($urandom_range(0, 3), 1'b1);
            total++; if (rd.y_valid !== 1'b1) begin bad++; $display("FAIL rand_y_valid frame=%0d got=%b exp=1", f, rd.y_valid); end
            total++; if (rd.y_dout !== model_result()) begin bad++; $display("FAIL rand_y_dout frame=%0d got=%h exp=%h", f, rd.y_dout, model_result()); end
            repeat ($urandom_range(1, 3)) step();
        end
    endtask

    initial begin
        rd.start        = 1'b0;
        rd.node_valid   = 1'b0;
        rd.node_din     = '0;
        rd.weight_wr_en = 1'b0;
        rd.weight_addr  = '0;
        rd.weight_din   = '0;
        test_reset();
        test_contiguous();
        test_gapped();
        test_saturation();
        test_abort();
        test_reset_midframe();
        test_read_before_write();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dfr_readout.md
Name: dfr_readout

Overview:
- Output (readout) layer of the delayed-feedback reservoir. It sits at the far end of the reservoir delay line.
- Consumes the serial stream of virtual-node states, one per enabled reservoir cycle.
- Multiplies each state by a trained, software-loaded output weight and accumulates across one frame of VIRTUAL_NODES states.
- Emits a single saturated dot-product result with a one-cycle valid pulse.

Parameters:
- VIRTUAL_NODES, 10: node states per frame; weight memory depth.
- DATA_WIDTH, 32: node state width (unsigned).
- WEIGHT_WIDTH, 32: output weight width (unsigned).
- ACC_WIDTH, 64: accumulator/result width; must be >= DATA_WIDTH + WEIGHT_WIDTH.
- ADDR_WIDTH, $clog2(VIRTUAL_NODES): weight address width.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse; begins a new frame.
- node_valid  input  1  node_din holds a valid node state this cycle (tied to reservoir en).
- node_din  input  DATA_WIDTH  node state (reservoir dout).
- weight_wr_en  input  1  weight write strobe.
- weight_addr  input  ADDR_WIDTH  weight index.
- weight_din  input  WEIGHT_WIDTH  weight value.
- busy  output  1  high in ACCUM and DONE.
- y_valid  output  1  one-cycle result strobe.
- y_dout  output  ACC_WIDTH  frame result; held until the next result.

Behaviour:
- Reset (rst=1 at a clock edge) has priority over everything:
  - state=IDLE, idx=0, acc=0, y_dout=0, y_valid=0, busy=0.
  - All weights cleared to 0.
  - An in-progress frame is discarded and no y_valid is produced.
- Weight memory:
  - Write when weight_wr_en=1 and weight_addr < VIRTUAL_NODES; addresses >= VIRTUAL_NODES are ignored.
  - Writes are allowed in any state.
  - A same-cycle write to the weight being consumed: the MAC uses the old value (read-before-write).
- FSM states: IDLE, ACCUM, DONE.
  - IDLE: node_valid is ignored. start=1 -> ACCUM with acc=0, idx=0.
  - ACCUM, node_valid=1: acc <= sat(acc + node_din*weight[idx]) and idx <= idx+1.
    - If idx == VIRTUAL_NODES-1, go to DONE instead of incrementing.
  - ACCUM, node_valid=0: hold acc and idx. There is no timeout.
  - ACCUM, start=1 (with or without node_valid): abort and restart. acc=0, idx=0, stay in ACCUM; the node on that cycle is not accumulated.
  - DONE (exactly one cycle): y_dout <= acc, y_valid=1, then -> IDLE.
    - node_valid in DONE is ignored.
    - start in DONE: the result is still emitted and the next state is ACCUM with a cleared acc/idx.
- Arithmetic:
  - Unsigned full-width product DATA_WIDTH+WEIGHT_WIDTH bits, zero-extended to ACC_WIDTH.
  - The sum saturates at 2^ACC_WIDTH-1 (all ones). Once saturated, acc stays saturated for the rest of the frame.
- Latency:
  - y_valid is asserted on the cycle after the clock edge that accepts the last node. That is one cycle after the last node_valid is sampled.
  - With contiguous node_valid, a frame takes VIRTUAL_NODES+1 cycles from the first accepted node to y_valid.
  - Minimum start-to-y_valid is VIRTUAL_NODES+2 cycles.
- busy is registered: high from the cycle after start through the DONE cycle.

Test Plan:
- Reset, load weights 1..10 at addresses 0..9, start, then 10 contiguous node_valid with node_din=0x0010_0000 -> y_valid one cycle after the 10th node; y_dout = 55*0x10_0000 = 0x0370_0000; busy low the next cycle.
- Same frame with node_valid gapped (1 on, 2 off) -> identical y_dout=0x0370_0000; y_valid still one cycle after the 10th accepted node; acc/idx held during gaps.
- All weights and node_din set to 0xFFFF_FFFF -> y_dout = 0xFFFF_FFFF_FFFF_FFFF (saturated, not wrapped); a write to weight_addr=12 leaves weights unchanged.
- After 5 nodes, pulse start with node_valid=1 -> the first frame is discarded; the next 10 nodes (din=1, weights 1..10) give y_dout=55; exactly one y_valid total.
- Assert rst mid-frame after 7 nodes -> no y_valid; y_dout=0; weights read back as 0 (a frame with din=1 gives y_dout=0).
- During ACCUM at idx=3, write weight[3]=100 (old value 4) in the same cycle, din=1 -> that node contributes 4. In the next frame weight[3]=100, so the result increases by 96.
